// File: rtl/uart_pkg.sv
// Shared definitions for the serial transceiver: parity modes, transmit FSM states
// and the parity helper used when a word is accepted.
package uart_pkg;

   localparam int PARITY_NONE   = 0;
   localparam int PARITY_ODD    = 1;
   localparam int PARITY_EVEN   = 2;
   localparam int MAX_DATA_BITS = 9;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Callers zero-extend the payload, so XOR over all MAX_DATA_BITS equals XOR over the payload.
   function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
      return (mode == PARITY_ODD) ? ~(^data) : (^data);
   endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Host-side word handshake plus the serial line and status outputs of the transmitter.
// master = byte source / observer, slave = uart_tx_frame.
interface uart_tx_frame_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic                 dout;
   logic                 tx_busy;
   logic                 tx_done;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready,
      input  dout,
      input  tx_busy,
      input  tx_done
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready,
      output dout,
      output tx_busy,
      output tx_done
   );
endinterface

// File: rtl/baud_tick_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled, tick on the last count.
// Synchronous clear restarts the bit period; no backpressure, tick is a single-cycle strobe.
module baud_tick_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised serial transmitter: start, DATA_BITS LSB first, optional parity, 1-2 stop bits.
// Start bit drives dout on the accept edge; tx_ready is high only in IDLE, so words wait in the source.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic            clk,
   input  logic            rst,
   uart_tx_frame_if.slave  tx_if
);

   localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

   tx_state_t            state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic                 par_q, par_d;
   logic                 accept;
   logic                 bit_tick;
   logic                 dout_d;
   logic                 done_d;

   assign accept = tx_if.tx_valid && (state_q == IDLE);

   baud_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .en   (state_q != IDLE),
      .tick (bit_tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      par_d     = par_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = START;
               shift_d   = tx_if.tx_data;
               par_d     = parity_bit(MAX_DATA_BITS'(tx_if.tx_data), PARITY_MODE);
               bit_cnt_d = '0;
            end
         end
         START: begin
            if (bit_tick) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (bit_tick) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_DATA) begin
                  bit_cnt_d = '0;
                  state_d   = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_tick) begin
               state_d   = STOP;
               bit_cnt_d = '0;
            end
         end
         STOP: begin
            // bit_cnt_q counts stop bits here so two stop bits need no extra counter
            if (bit_tick) begin
               if (bit_cnt_q == LAST_STOP) begin
                  state_d   = IDLE;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level is decoded from the next state so dout is registered yet aligned with state.
   always_comb begin
      dout_d = 1'b1;
      case (state_d)
         START:   dout_d = 1'b0;
         DATA:    dout_d = shift_d[0];
         PARITY:  dout_d = par_d;
         default: dout_d = 1'b1;
      endcase
      done_d = (state_q == STOP) && (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         shift_q        <= '0;
         bit_cnt_q      <= '0;
         par_q          <= 1'b0;
         tx_if.dout     <= 1'b1;
         tx_if.tx_ready <= 1'b1;
         tx_if.tx_busy  <= 1'b0;
         tx_if.tx_done  <= 1'b0;
      end else begin
         state_q        <= state_d;
         shift_q        <= shift_d;
         bit_cnt_q      <= bit_cnt_d;
         par_q          <= par_d;
         tx_if.dout     <= dout_d;
         tx_if.tx_ready <= (state_d == IDLE);
         tx_if.tx_busy  <= (state_d != IDLE);
         tx_if.tx_done  <= done_d;
      end
   end

endmodule
